mc_control_fsm: RTL and testbench
=================================

// Module: mc_control_fsm
// PURPOSE
//  Multicycle MIPS main control unit; drives every control input of the datapath.
//  Consumes the datapath's opcode (Instr_31_26) and zero flag (zf).
//  Moore FSM sequences FETCH/DECODE/execute states per opcode and produces PC_En from branch zero.
//  Also keeps a retired-instruction counter and a sticky illegal-opcode flag for debug/test.
// PARAMETERS
//  CNT_W      32        width of retired-instruction counter
//  OP_RTYPE   6'b000000 R-type opcode
//  OP_LW      6'b100011 load word
//  OP_SW      6'b101011 store word
//  OP_BEQ     6'b000100 branch if equal
//  OP_J       6'b000010 jump
//  OP_ADDI    6'b001000 add immediate
// PORTS
//  clk          in   1      rising-edge clock, shared with the datapath
//  rst_n        in   1      asynchronous active-low reset
//  Instr_31_26  in   6      opcode from the instruction register
//  zf           in   1      ALU zero flag (combinational from the datapath)
//  MemRead, MemWrite, IRWrite, RegDst, RegWrite, ALUSrcA, IorD, MemtoReg, PC_En  out 1 each
//  ALUSrcB      out  2      00 B, 01 const 1, 10 sign-ext imm, 11 sign-ext imm<<2
//  PCSource     out  2      00 ALUresult, 01 ALUOut, 10 jump target
//  ALU_OP       out  2      00 add, 01 sub, 10 funct field
//  state_o      out  4      current state encoding (debug)
//  illegal_op   out  1      sticky; set on an undefined opcode
//  retired      out  CNT_W  count of completed instructions
// BEHAVIOUR
//  Reset (async, rst_n=0): state=IDLE, illegal_op=0, retired=0; all controls 0 (PC_En=0).
//  IDLE -> FETCH on the first clk after rst_n rises. Reset mid-instruction aborts it immediately.
//  Outputs are a pure decode of the state register. Exception: PC_En in BEQ = zf.
//  Controls not listed for a state are 0.
//   FETCH:    MemRead,IRWrite,PC_En=1; IorD=0; ALUSrcA=0; ALUSrcB=01; ALU_OP=00; PCSource=00
//   DECODE:   ALUSrcA=0; ALUSrcB=11; ALU_OP=00 (branch target -> ALUOut)
//   MEMADR:   ALUSrcA=1; ALUSrcB=10; ALU_OP=00
//   MEMRD:    MemRead=1; IorD=1
//   MEMWB:    RegWrite=1; RegDst=0; MemtoReg=1
//   MEMWR:    MemWrite=1; IorD=1
//   RTYPE_EX: ALUSrcA=1; ALUSrcB=00; ALU_OP=10
//   RTYPE_WB: RegWrite=1; RegDst=1; MemtoReg=0
//   BEQ:      ALUSrcA=1; ALUSrcB=00; ALU_OP=01; PCSource=01; PC_En=zf
//   JUMP:     PCSource=10; PC_En=1
//   ADDI_EX:  ALUSrcA=1; ALUSrcB=10; ALU_OP=00
//   ADDI_WB:  RegWrite=1; RegDst=0; MemtoReg=0
//   ERROR:    all controls 0; absorbing until reset
//  Transitions: FETCH->DECODE. DECODE dispatches on Instr_31_26:
//   LW/SW->MEMADR; RTYPE->RTYPE_EX; BEQ->BEQ; J->JUMP; ADDI->ADDI_EX; other->ERROR.
//  MEMADR->MEMRD (LW) or MEMWR (SW). MEMRD->MEMWB.
//  RTYPE_EX->RTYPE_WB. ADDI_EX->ADDI_WB.
//  MEMWB, MEMWR, RTYPE_WB, ADDI_WB, BEQ, JUMP -> FETCH.
//  Latency in cycles, FETCH to last state inclusive: LW 5, SW/R/ADDI 4, BEQ/J 3.
//  Opcode is sampled only in DECODE and MEMADR. Changes at other times are ignored.
//  retired increments by 1 on each terminal-state cycle (the clock edge into FETCH).
//   It wraps modulo 2^CNT_W and does not increment in ERROR.
//  illegal_op is set on the DECODE->ERROR edge and cleared only by reset.
// STRUCTURE
//  Package mc_ctrl_pkg: state localparams (4-bit), opcode constants, ALU_OP/ALUSrcB/PCSource codes.
//  Sub-module mc_ctrl_decode: combinational state(+zf) -> control-word decode.
//  Top module holds the state register, next-state logic, counter and flag.
// TESTING
//  1 rst_n low mid-MEMRD -> all controls 0, state_o=IDLE; 1 clk after release -> FETCH with PC_En=1.
//  2 LW (100011) -> FETCH,DECODE,MEMADR,MEMRD,MEMWB over 5 clk; MemtoReg=1,RegWrite=1 in cycle 5; retired +1.
//  3 BEQ with zf=1 -> PC_En=1,PCSource=01 in cycle 3. With zf=0 -> PC_En=0. Both return to FETCH.
//  4 R-type then ADDI back-to-back -> RegDst=1 in RTYPE_WB, RegDst=0 in ADDI_WB; retired=2 after 8 clk.
//  5 opcode 6'b111111 -> ERROR after DECODE; illegal_op=1; controls stay 0; retired frozen.
//  6 CNT_W=4, 16 J instructions -> retired wraps 15->0; JUMP shows PCSource=10,PC_En=1.

Source files
------------

// File: rtl/mc_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// mc_ctrl_pkg : state codes, opcodes and control-field encodings (rev 1.0)
// ---------------------------------------------------------------------------
`default_nettype none

package mc_ctrl_pkg;

    localparam logic [3:0] S_IDLE     = 4'd0;
    localparam logic [3:0] S_FETCH    = 4'd1;
    localparam logic [3:0] S_DECODE   = 4'd2;
    localparam logic [3:0] S_MEMADR   = 4'd3;
    localparam logic [3:0] S_MEMRD    = 4'd4;
    localparam logic [3:0] S_MEMWB    = 4'd5;
    localparam logic [3:0] S_MEMWR    = 4'd6;
    localparam logic [3:0] S_RTYPE_EX = 4'd7;
    localparam logic [3:0] S_RTYPE_WB = 4'd8;
    localparam logic [3:0] S_BEQ      = 4'd9;
    localparam logic [3:0] S_JUMP     = 4'd10;
    localparam logic [3:0] S_ADDI_EX  = 4'd11;
    localparam logic [3:0] S_ADDI_WB  = 4'd12;
    localparam logic [3:0] S_ERROR    = 4'd13;

    localparam logic [5:0] OPC_RTYPE = 6'b000000;
    localparam logic [5:0] OPC_LW    = 6'b100011;
    localparam logic [5:0] OPC_SW    = 6'b101011;
    localparam logic [5:0] OPC_BEQ   = 6'b000100;
    localparam logic [5:0] OPC_J     = 6'b000010;
    localparam logic [5:0] OPC_ADDI  = 6'b001000;

    localparam logic [1:0] ALU_ADD   = 2'b00;
    localparam logic [1:0] ALU_SUB   = 2'b01;
    localparam logic [1:0] ALU_FUNCT = 2'b10;

    localparam logic [1:0] SRCB_B       = 2'b00;
    localparam logic [1:0] SRCB_ONE     = 2'b01;
    localparam logic [1:0] SRCB_IMM     = 2'b10;
    localparam logic [1:0] SRCB_IMM_SL2 = 2'b11;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    typedef struct packed {
        logic       mem_read;
        logic       mem_write;
        logic       ir_write;
        logic       reg_dst;
        logic       reg_write;
        logic       alu_src_a;
        logic       ior_d;
        logic       mem_to_reg;
        logic       pc_en;
        logic [1:0] alu_src_b;
        logic [1:0] pc_source;
        logic [1:0] alu_op;
    } ctrl_t;

    // Last state of every instruction; its exit edge retires the instruction.
    function automatic logic is_terminal(input logic [3:0] s);
        return (s == S_MEMWB)    || (s == S_MEMWR) || (s == S_RTYPE_WB) ||
               (s == S_ADDI_WB)  || (s == S_BEQ)   || (s == S_JUMP);
    endfunction

endpackage

`default_nettype wire

// File: rtl/mc_ctrl_decode.sv
// ---------------------------------------------------------------------------
// mc_ctrl_decode : state (+zf) to datapath control word (rev 1.0)
// ---------------------------------------------------------------------------
`default_nettype none

module mc_ctrl_decode
    import mc_ctrl_pkg::*;
(
    input  logic [3:0] state,
    input  logic       zf,
    output ctrl_t      ctrl
);

    always_comb begin
        ctrl = '0;
        case (state)
            S_FETCH: begin
                ctrl.mem_read  = 1'b1;
                ctrl.ir_write  = 1'b1;
                ctrl.pc_en     = 1'b1;
                ctrl.alu_src_b = SRCB_ONE;
                ctrl.alu_op    = ALU_ADD;
                ctrl.pc_source = PCSRC_ALU;
            end
            S_DECODE:   ctrl.alu_src_b = SRCB_IMM_SL2;
            S_MEMADR: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = SRCB_IMM;
            end
            S_MEMRD: begin
                ctrl.mem_read = 1'b1;
                ctrl.ior_d    = 1'b1;
            end
            S_MEMWB: begin
                ctrl.reg_write  = 1'b1;
                ctrl.mem_to_reg = 1'b1;
            end
            S_MEMWR: begin
                ctrl.mem_write = 1'b1;
                ctrl.ior_d     = 1'b1;
            end
            S_RTYPE_EX: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = SRCB_B;
                ctrl.alu_op    = ALU_FUNCT;
            end
            S_RTYPE_WB: begin
                ctrl.reg_write = 1'b1;
                ctrl.reg_dst   = 1'b1;
            end
            // Only state whose output depends on anything but the state register.
            S_BEQ: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_op    = ALU_SUB;
                ctrl.pc_source = PCSRC_ALUOUT;
                ctrl.pc_en     = zf;
            end
            S_JUMP: begin
                ctrl.pc_source = PCSRC_JUMP;
                ctrl.pc_en     = 1'b1;
            end
            S_ADDI_EX: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = SRCB_IMM;
            end
            S_ADDI_WB:  ctrl.reg_write = 1'b1;
            default:    ctrl = '0;
        endcase
    end

endmodule

`default_nettype wire

// File: rtl/mc_control_fsm.sv
// ---------------------------------------------------------------------------
// mc_control_fsm : multicycle MIPS main control FSM with debug counter (rev 1.0)
// ---------------------------------------------------------------------------
`default_nettype none

module mc_control_fsm
    import mc_ctrl_pkg::*;
#(
    parameter int         CNT_W    = 32,
    parameter logic [5:0] OP_RTYPE = OPC_RTYPE,
    parameter logic [5:0] OP_LW    = OPC_LW,
    parameter logic [5:0] OP_SW    = OPC_SW,
    parameter logic [5:0] OP_BEQ   = OPC_BEQ,
    parameter logic [5:0] OP_J     = OPC_J,
    parameter logic [5:0] OP_ADDI  = OPC_ADDI
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [5:0]       Instr_31_26,
    input  logic             zf,
    output logic             MemRead,
    output logic             MemWrite,
    output logic             IRWrite,
    output logic             RegDst,
    output logic             RegWrite,
    output logic             ALUSrcA,
    output logic             IorD,
    output logic             MemtoReg,
    output logic             PC_En,
    output logic [1:0]       ALUSrcB,
    output logic [1:0]       PCSource,
    output logic [1:0]       ALU_OP,
    output logic [3:0]       state_o,
    output logic             illegal_op,
    output logic [CNT_W-1:0] retired
);

    logic [3:0] state;
    logic [3:0] state_nx;
    ctrl_t      ctrl;

    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE:     state_nx = S_FETCH;
            S_FETCH:    state_nx = S_DECODE;
            S_DECODE: begin
                if ((Instr_31_26 == OP_LW) || (Instr_31_26 == OP_SW))
                    state_nx = S_MEMADR;
                else if (Instr_31_26 == OP_RTYPE)
                    state_nx = S_RTYPE_EX;
                else if (Instr_31_26 == OP_BEQ)
                    state_nx = S_BEQ;
                else if (Instr_31_26 == OP_J)
                    state_nx = S_JUMP;
                else if (Instr_31_26 == OP_ADDI)
                    state_nx = S_ADDI_EX;
                else
                    state_nx = S_ERROR;
            end
            S_MEMADR:   state_nx = (Instr_31_26 == OP_SW) ? S_MEMWR : S_MEMRD;
            S_MEMRD:    state_nx = S_MEMWB;
            S_RTYPE_EX: state_nx = S_RTYPE_WB;
            S_ADDI_EX:  state_nx = S_ADDI_WB;
            S_MEMWB, S_MEMWR, S_RTYPE_WB, S_ADDI_WB, S_BEQ, S_JUMP:
                        state_nx = S_FETCH;
            S_ERROR:    state_nx = S_ERROR;
            default:    state_nx = S_ERROR;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= S_IDLE;
            illegal_op <= 1'b0;
            retired    <= '0;
        end else begin
            state <= state_nx;
            if ((state == S_DECODE) && (state_nx == S_ERROR))
                illegal_op <= 1'b1;
            if (is_terminal(state))
                retired <= retired + CNT_W'(1);
        end
    end

    mc_ctrl_decode u_decode (
        .state (state),
        .zf    (zf),
        .ctrl  (ctrl)
    );

    assign MemRead  = ctrl.mem_read;
    assign MemWrite = ctrl.mem_write;
    assign IRWrite  = ctrl.ir_write;
    assign RegDst   = ctrl.reg_dst;
    assign RegWrite = ctrl.reg_write;
    assign ALUSrcA  = ctrl.alu_src_a;
    assign IorD     = ctrl.ior_d;
    assign MemtoReg = ctrl.mem_to_reg;
    assign PC_En    = ctrl.pc_en;
    assign ALUSrcB  = ctrl.alu_src_b;
    assign PCSource = ctrl.pc_source;
    assign ALU_OP   = ctrl.alu_op;
    assign state_o  = state;

endmodule

`default_nettype wire

// File: tb/tb_mc_control_fsm.sv
// ---------------------------------------------------------------------------
// tb_mc_control_fsm : scoreboard bench for mc_control_fsm (rev 1.0)
// ---------------------------------------------------------------------------
`default_nettype none

module tb_mc_control_fsm;
    import mc_ctrl_pkg::*;

    localparam int CW = 4;

    localparam logic [5:0] T_RTYPE = 6'b000000;
    localparam logic [5:0] T_LW    = 6'b100011;
    localparam logic [5:0] T_SW    = 6'b101011;
    localparam logic [5:0] T_BEQ   = 6'b000100;
    localparam logic [5:0] T_J     = 6'b000010;
    localparam logic [5:0] T_ADDI  = 6'b001000;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [5:0]    instr = 6'd0;
    logic          zf = 1'b0;
    logic          mem_read, mem_write, ir_write, reg_dst, reg_write;
    logic          alu_src_a, ior_d, mem_to_reg, pc_en;
    logic [1:0]    alu_src_b, pc_source, alu_op;
    logic [3:0]    state_o;
    logic          illegal_op;
    logic [CW-1:0] retired;

    typedef struct packed {
        logic [3:0]    st;
        logic          mr, mw, irw, rd, rw, asa, iod, m2r, pce;
        logic [1:0]    srcb, pcs, aop;
        logic          ill;
        logic [CW-1:0] ret;
    } obs_t;

    obs_t          q[$];
    int            vectors = 0;
    int            miscompares = 0;
    logic [CW-1:0] m_ret = '0;
    logic          m_ill = 1'b0;

    always #5 clk = ~clk;

    mc_control_fsm #(.CNT_W(CW)) dut (
        .clk(clk), .rst_n(rst_n), .Instr_31_26(instr), .zf(zf),
        .MemRead(mem_read), .MemWrite(mem_write), .IRWrite(ir_write),
        .RegDst(reg_dst), .RegWrite(reg_write), .ALUSrcA(alu_src_a),
        .IorD(ior_d), .MemtoReg(mem_to_reg), .PC_En(pc_en),
        .ALUSrcB(alu_src_b), .PCSource(pc_source), .ALU_OP(alu_op),
        .state_o(state_o), .illegal_op(illegal_op), .retired(retired)
    );

    function automatic obs_t expect_for(input logic [3:0] st, input logic z);
        obs_t e = '0;
        e.st  = st;
        e.ill = m_ill;
        e.ret = m_ret;
        case (st)
            S_FETCH:    begin e.mr = 1; e.irw = 1; e.pce = 1; e.srcb = 2'b01; end
            S_DECODE:   e.srcb = 2'b11;
            S_MEMADR:   begin e.asa = 1; e.srcb = 2'b10; end
            S_MEMRD:    begin e.mr = 1; e.iod = 1; end
            S_MEMWB:    begin e.rw = 1; e.m2r = 1; end
            S_MEMWR:    begin e.mw = 1; e.iod = 1; end
            S_RTYPE_EX: begin e.asa = 1; e.aop = 2'b10; end
            S_RTYPE_WB: begin e.rw = 1; e.rd = 1; end
            S_BEQ:      begin e.asa = 1; e.aop = 2'b01; e.pcs = 2'b01; e.pce = z; end
            S_JUMP:     begin e.pcs = 2'b10; e.pce = 1; end
            S_ADDI_EX:  begin e.asa = 1; e.srcb = 2'b10; end
            S_ADDI_WB:  e.rw = 1;
            default:    ;
        endcase
        return e;
    endfunction

    // zsel: 0/1 forces zf, 2 randomises it
    task automatic step(input logic [3:0] st, input logic [5:0] op,
                        input logic drive_op, input int zsel);
        @(posedge clk);
        #1;
        instr = drive_op ? op : 6'($urandom);
        zf    = (zsel == 2) ? 1'($urandom) : 1'(zsel);
        q.push_back(expect_for(st, zf));
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        instr = 6'($urandom);
        m_ret = '0;
        m_ill = 1'b0;
        q.push_back(expect_for(S_IDLE, 1'b0));
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        q.push_back(expect_for(S_IDLE, 1'b0));
    endtask

    // One instruction as the ordered list of states it visits.
    task automatic run_instr(input logic [5:0] op, input int zsel);
        step(S_FETCH, op, 1'b0, zsel);
        step(S_DECODE, op, 1'b1, zsel);
        if (op == T_LW) begin
            step(S_MEMADR, op, 1'b1, zsel);
            step(S_MEMRD, op, 1'b0, zsel);
            step(S_MEMWB, op, 1'b0, zsel);
        end else if (op == T_SW) begin
            step(S_MEMADR, op, 1'b1, zsel);
            step(S_MEMWR, op, 1'b0, zsel);
        end else if (op == T_RTYPE) begin
            step(S_RTYPE_EX, op, 1'b0, zsel);
            step(S_RTYPE_WB, op, 1'b0, zsel);
        end else if (op == T_ADDI) begin
            step(S_ADDI_EX, op, 1'b0, zsel);
            step(S_ADDI_WB, op, 1'b0, zsel);
        end else if (op == T_BEQ) begin
            step(S_BEQ, op, 1'b0, zsel);
        end else if (op == T_J) begin
            step(S_JUMP, op, 1'b0, zsel);
        end else begin
            m_ill = 1'b1;
            repeat (4) step(S_ERROR, op, 1'b0, zsel);
            return;
        end
        m_ret = m_ret + 1'b1;
    endtask

    always @(negedge clk) begin
        obs_t e;
        obs_t a;
        if (q.size() > 0) begin
            e = q.pop_front();
            a = {state_o, mem_read, mem_write, ir_write, reg_dst, reg_write,
                 alu_src_a, ior_d, mem_to_reg, pc_en, alu_src_b, pc_source,
                 alu_op, illegal_op, retired};
            vectors++;
            if (a !== e) begin
                miscompares++;
                $display("FAIL ctrl_word t=%0t exp_state=%0d: actual=%h required=%h (state %0d/%0d pc_en %b/%b retired %0d/%0d illegal %b/%b)",
                         $time, e.st, a, e, a.st, e.st, a.pce, e.pce, a.ret, e.ret, a.ill, e.ill);
            end
        end
    end

    logic [5:0] legal_ops [6];

    initial begin
        legal_ops[0] = T_RTYPE; legal_ops[1] = T_LW;  legal_ops[2] = T_SW;
        legal_ops[3] = T_BEQ;   legal_ops[4] = T_J;   legal_ops[5] = T_ADDI;

        do_reset();
        run_instr(T_RTYPE, 2);
        run_instr(T_ADDI, 2);
        run_instr(T_LW, 2);
        run_instr(T_BEQ, 1);
        run_instr(T_BEQ, 0);
        repeat (18) run_instr(T_J, 2);

        // abort an LW while it is in flight
        step(S_FETCH, T_LW, 1'b0, 2);
        step(S_DECODE, T_LW, 1'b1, 2);
        step(S_MEMADR, T_LW, 1'b1, 2);
        step(S_MEMRD, T_LW, 1'b0, 2);
        do_reset();
        run_instr(T_SW, 2);

        for (int i = 0; i < 150; i++)
            run_instr(legal_ops[$urandom_range(0, 5)], 2);

        run_instr(6'b111111, 2);
        do_reset();
        run_instr(T_LW, 2);
        run_instr(6'b010101, 2);
        do_reset();
        run_instr(T_BEQ, 2);

        repeat (3) @(negedge clk);
        if (q.size() != 0) begin
            miscompares++;
            $display("FAIL scoreboard_drain: actual %0d pending entries, required 0", q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

`default_nettype wire
